vc_qspi_ctrl: RTL

VC_QSPI_CTRL -- requirements
Module: vc_qspi_ctrl

---
 rtl/vc_qspi_ctrl_if.sv | 14 +
 rtl/vc_qspi_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vc_qspi_ctrl_if.sv
// CPU-side request/acknowledge bus for the QSPI memory controller.
interface vc_qspi_ctrl_if #(
  parameter int PA = 24
);
  logic          req;
  logic          we;
  logic [PA-1:0] addr;
  logic [15:0]   wdata;
  logic [15:0]   rdata;
  logic          ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/vc_qspi_ctrl.sv
// Quad-SPI memory controller: 16-bit CPU reads (0xEB) and writes (0x38), one nibble per two clk cycles.
// Define VC_QSPI_SEQ_EN to keep cs_n low after a read and stream the next sequential halfword.
module vc_qspi_ctrl #(
  parameter int PA    = 24,
  parameter int DUMMY = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  vc_qspi_ctrl_if.slave bus,
  output logic          qspi_cs_n,
  output logic          qspi_sck,
  output logic [3:0]    qspi_io_out,
  output logic [3:0]    qspi_io_oe,
  input  logic [3:0]    qspi_io_in
);

  localparam int NA = PA / 4;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
`ifdef VC_QSPI_SEQ_EN
    , S_HOLD
`endif
  } state_t;

  state_t        state_q;
  logic          phase_q;
  logic [5:0]    cnt_q;
  logic          we_q;
  logic [PA-1:0] ash_q;
  logic [15:0]   wsh_q;
  logic [11:0]   rsh_q;
  logic          cs_n_q;
  logic          sck_q;
  logic [3:0]    io_out_q;
  logic [3:0]    io_oe_q;
  logic          ack_q;
  logic [15:0]   rdata_q;
`ifdef VC_QSPI_SEQ_EN
  logic [PA-1:0] addr_q;
`endif

  // Every output is registered: each transition sets what the pins show in the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      phase_q  <= 1'b0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      ash_q    <= '0;
      wsh_q    <= '0;
      rsh_q    <= '0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      io_out_q <= 4'h0;
      io_oe_q  <= 4'h0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
`ifdef VC_QSPI_SEQ_EN
      addr_q   <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cs_n_q   <= 1'b1;
          sck_q    <= 1'b0;
          io_oe_q  <= 4'h0;
          io_out_q <= 4'h0;
          if (bus.req) begin
            we_q     <= bus.we;
            ash_q    <= bus.addr;
            wsh_q    <= {bus.wdata[7:0], bus.wdata[15:8]};
`ifdef VC_QSPI_SEQ_EN
            addr_q   <= bus.addr;
`endif
            state_q  <= S_CMD;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            cs_n_q   <= 1'b0;
            io_oe_q  <= 4'hF;
            io_out_q <= bus.we ? 4'h3 : 4'hE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
`ifdef VC_QSPI_SEQ_EN
        S_HOLD: begin
          if (bus.req) begin
            if (!bus.we && (bus.addr == addr_q + PA'(2))) begin
              addr_q  <= bus.addr;
              state_q <= S_DATA;
              cnt_q   <= '0;
              phase_q <= 1'b0;
            end else begin
              cs_n_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
`endif
        default: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            sck_q   <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            sck_q   <= 1'b0;
            cnt_q   <= cnt_q + 6'd1;
            case (state_q)
              S_CMD: begin
                if (cnt_q == 6'd0) begin
                  io_out_q <= we_q ? 4'h8 : 4'hB;
                end else begin
                  state_q  <= S_ADDR;
                  cnt_q    <= '0;
                  io_out_q <= ash_q[PA-1 -: 4];
                  ash_q    <= ash_q << 4;
                end
              end
              S_ADDR: begin
                if (cnt_q != 6'(NA - 1)) begin
                  io_out_q <= ash_q[PA-1 -: 4];
                  ash_q    <= ash_q << 4;
                end else if (we_q) begin
                  state_q  <= S_DATA;
                  cnt_q    <= '0;
                  io_out_q <= wsh_q[15:12];
                  wsh_q    <= wsh_q << 4;
                end else begin
                  state_q  <= S_DUMMY;
                  cnt_q    <= '0;
                  io_oe_q  <= 4'h0;
                  io_out_q <= 4'h0;
                end
              end
              S_DUMMY: begin
                if (cnt_q == 6'(DUMMY - 1)) begin
                  state_q <= S_DATA;
                  cnt_q   <= '0;
                end
              end
              S_DATA: begin
                // Nibbles arrive low byte first, high nibble first within each byte.
                if (!we_q) rsh_q <= {rsh_q[7:0], qspi_io_in};
                if (cnt_q != 6'd3) begin
                  if (we_q) io_out_q <= wsh_q[15:12];
                  wsh_q <= wsh_q << 4;
                end else begin
                  io_oe_q  <= 4'h0;
                  io_out_q <= 4'h0;
                  ack_q    <= 1'b1;
                  if (!we_q) rdata_q <= {rsh_q[3:0], qspi_io_in, rsh_q[11:4]};
`ifdef VC_QSPI_SEQ_EN
                  if (!we_q) begin
                    state_q <= S_HOLD;
                  end else begin
                    state_q <= S_DONE;
                    cs_n_q  <= 1'b1;
                  end
`else
                  state_q <= S_DONE;
                  cs_n_q  <= 1'b1;
`endif
                end
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.ack     = ack_q;
  assign bus.rdata   = rdata_q;
  assign qspi_cs_n   = cs_n_q;
  assign qspi_sck    = sck_q;
  assign qspi_io_out = io_out_q;
  assign qspi_io_oe  = io_oe_q;

endmodule
